// File: rtl/scemi_input_pipe_buffer_if.sv
// Handshake bundle between a SCE-MI input pipe buffer and its
// host-side writer / DUT-side receiver.
interface scemi_input_pipe_buffer_if #(
  parameter int EW = 8,
  parameter int NW = 3,
  parameter int PW = 32,
  parameter int CW = 5
);
  logic          wr_valid;
  logic          wr_ready;
  logic [EW-1:0] wr_data;
  logic          wr_eom;
  logic          rd_req;
  logic [NW-1:0] rd_num;
  logic          rd_ready;
  logic          rd_done;
  logic [NW-1:0] rd_num_valid;
  logic [PW-1:0] rd_data;
  logic          rd_eom;
  logic [CW-1:0] can_receive;
  logic          notify;

  modport master (
    output wr_valid, wr_data, wr_eom,
    output rd_req, rd_num,
    input  wr_ready, rd_ready, rd_done,
    input  rd_num_valid, rd_data, rd_eom,
    input  can_receive, notify
  );

  modport slave (
    input  wr_valid, wr_data, wr_eom,
    input  rd_req, rd_num,
    output wr_ready, rd_ready, rd_done,
    output rd_num_valid, rd_data, rd_eom,
    output can_receive, notify
  );
endinterface

// File: rtl/scemi_input_pipe_buffer.sv
// SCE-MI input pipe buffer: element FIFO with deferred visibility,
// blocking multi-element receive FSM and free-slot notification.
module scemi_input_pipe_buffer #(
  parameter int BYTES_PER_ELEMENT      = 1,
  parameter int PAYLOAD_MAX_ELEMENTS   = 4,
  parameter int BUFFER_MAX_ELEMENTS    = 16,
  parameter int VISIBILITY_MODE        = 0,
  parameter int NOTIFICATION_THRESHOLD = BUFFER_MAX_ELEMENTS
) (
  input  logic clk,
  input  logic rst,
  scemi_input_pipe_buffer_if.slave pipe
);
  localparam int EW  = 8 * BYTES_PER_ELEMENT;
  localparam int PME = PAYLOAD_MAX_ELEMENTS;
  localparam int BME = BUFFER_MAX_ELEMENTS;
  localparam int NW  = $clog2(PME + 1);
  localparam int PW  = PME * EW;
  localparam int CW  = $clog2(BME + 1);
  localparam int AW  = $clog2(BME);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GATHER = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [EW:0]   mem_q [BME];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] commit_q, commit_d;
  logic [CW-1:0] unc_q, unc_d;
  logic [1:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [NW-1:0] num_q, num_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] data_q, data_d;
  logic          eom_q, eom_d;
  logic          prev_q;

  logic [CW-1:0] vis;
  logic [CW-1:0] free;
  logic [NW-1:0] req_n;
  logic [EW:0]   head;
  logic          push, pop, cond;

  assign vis   = (VISIBILITY_MODE != 0) ? commit_q : count_q;
  assign push  = pipe.wr_valid && (count_q < CW'(BME));
  assign pop   = (state_q == S_GATHER) && (vis != '0);
  assign head  = mem_q[rptr_q];
  assign req_n = (pipe.rd_num > NW'(PME)) ? NW'(PME) : pipe.rd_num;
  assign free  = CW'(BME) - count_q;
  assign cond  = free >= CW'(NOTIFICATION_THRESHOLD);

  assign pipe.wr_ready     = count_q < CW'(BME);
  assign pipe.rd_ready     = state_q == S_IDLE;
  assign pipe.rd_done      = state_q == S_DONE;
  assign pipe.rd_num_valid = num_q;
  assign pipe.rd_data      = data_q;
  assign pipe.rd_eom       = eom_q;
  assign pipe.can_receive  = vis;
  assign pipe.notify       = cond && !prev_q;

  // Committed elements become visible once their message's eom lands.
  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    commit_d = commit_q - CW'(pop);
    unc_d    = unc_q;
    if (push) begin
      if (pipe.wr_eom) begin
        commit_d = commit_d + unc_q + CW'(1);
        unc_d    = '0;
      end else begin
        unc_d = unc_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    num_d   = num_q;
    data_d  = data_q;
    eom_d   = eom_q;
    unique case (state_q)
      S_IDLE: begin
        if (pipe.rd_req) begin
          n_d   = req_n;
          idx_d = '0;
          acc_d = '0;
          if (req_n == '0) begin
            state_d = S_DONE;
            num_d   = '0;
            data_d  = '0;
            eom_d   = 1'b0;
          end else begin
            state_d = S_GATHER;
          end
        end
      end
      S_GATHER: begin
        if (pop) begin
          for (int k = 0; k < PME; k++) begin
            if (idx_q == NW'(k)) acc_d[k*EW +: EW] = head[EW-1:0];
          end
          idx_d = idx_q + NW'(1);
          if (idx_d == n_q || head[EW]) begin
            state_d = S_DONE;
            num_d   = idx_d;
            data_d  = acc_d;
            eom_d   = head[EW];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {pipe.wr_eom, pipe.wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      commit_q <= '0;
      unc_q    <= '0;
      state_q  <= S_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      num_q    <= '0;
      data_q   <= '0;
      eom_q    <= 1'b0;
      prev_q   <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q  <= count_d;
      commit_q <= commit_d;
      unc_q    <= unc_d;
      state_q  <= state_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      num_q    <= num_d;
      data_q   <= data_d;
      eom_q    <= eom_d;
      prev_q   <= cond;
    end
  end
endmodule
